// File: rtl/input_port_module.sv
// rtl/input_port_module.sv - memory-mapped debounced input port with masked sticky change flags
// Optional INPUT_PORT_IRQ_EN: registered irq = |flags_next; otherwise irq is tied low.
module input_port_module #(
    parameter int WIDTH    = 10,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             nce,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      d_in,
    output logic [31:0]      d_out,
    input  logic [WIDTH-1:0] pins,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync1, sync2, state, flags, mask;
    logic [WIDTH-1:0] state_next, ev, clr, flags_next;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic             bus_wr, bus_rd;

    assign bus_wr = !nce && we;
    assign bus_rd = !nce && !we;

    // A bit flips only after DEBOUNCE consecutive mismatching samples; any match restarts the count.
    always_comb begin
        state_next = state;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != state[i]) begin
                if (cnt[i] == CNT_MAX)
                    state_next[i] = sync2[i];
                else
                    cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
        ev         = (state_next ^ state) & mask;
        clr        = (bus_wr && addr == 2'd1) ? d_in[WIDTH-1:0] : '0;
        flags_next = (flags & ~clr) | ev;
    end

    always_ff @(negedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1 <= '0;
            sync2 <= '0;
            state <= '0;
            flags <= '0;
            mask  <= '0;
            cnt   <= '{default: '0};
            d_out <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
            state <= state_next;
            cnt   <= cnt_next;
            flags <= flags_next;
            if (bus_wr && addr == 2'd2)
                mask <= d_in[WIDTH-1:0];
            // Read data is the pre-update register value.
            if (bus_rd) begin
                case (addr)
                    2'd0:    d_out <= 32'(state);
                    2'd1:    d_out <= 32'(flags);
                    2'd2:    d_out <= 32'(mask);
                    default: d_out <= '0;
                endcase
            end
        end
    end

`ifdef INPUT_PORT_IRQ_EN
    always_ff @(negedge clk or negedge nrst) begin
        if (!nrst)
            irq <= 1'b0;
        else
            irq <= |flags_next;
    end
`else
    assign irq = 1'b0;
`endif

    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^d_in[31:WIDTH];
        end
    endgenerate

endmodule
